// File: rtl/aes_spi_scheduler.sv
// ---------------------------------------------------------------------------
// aes_spi_scheduler : round-robin sequencer for the shared AES SPI link. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_spi_scheduler #(
  parameter int DATA_BITS   = 128,
  parameter int KEY_BITS    = 256,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 mode0_i,
  input  logic                 mode1_i,
  input  logic [1:0]           nk0_i,
  input  logic [1:0]           nk1_i,
  input  logic [DATA_BITS-1:0] data0_i,
  input  logic [DATA_BITS-1:0] data1_i,
  input  logic [KEY_BITS-1:0]  key0_i,
  input  logic [KEY_BITS-1:0]  key1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 done0_o,
  output logic                 done1_o,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 busy_o,
  output logic [1:0]           nk_val_o,
  output logic                 mosi_o,
  output logic                 cs_enc_n_o,
  output logic                 cs_dec_n_o,
  input  logic                 miso_enc_i,
  input  logic                 miso_dec_i
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_TX_DATA = 3'd2,
    S_TX_KEY  = 3'd3,
    S_WAIT    = 3'd4,
    S_RX      = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int FRAME_BITS = DATA_BITS + KEY_BITS;
  // The LOAD cycle already drives the first data bit, so TX_DATA covers one fewer.
  localparam logic [8:0] c_DATA_LAST = 9'(DATA_BITS - 2);
  localparam logic [8:0] c_KEY_LAST  = 9'(KEY_BITS - 1);
  localparam logic [8:0] c_WAIT_LAST = 9'(WAIT_CYCLES - 1);
  localparam logic [8:0] c_RX_LAST   = 9'(DATA_BITS - 1);

  state_t                 state_q;
  logic [8:0]             cnt_q;
  logic                   sel1_q;
  logic                   prio1_q;
  logic                   mode_q;
  logic [1:0]             nk_q;
  logic [FRAME_BITS-1:0]  tx_q;
  logic [DATA_BITS-1:0]   rx_q;
  logic [DATA_BITS-1:0]   data_out_q;
  logic                   gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic                   mosi_q, cs_enc_n_q, cs_dec_n_q;

  logic                   w_win1;
  logic                   w_mode;
  logic [1:0]             w_nk;
  logic [DATA_BITS-1:0]   w_data;
  logic [KEY_BITS-1:0]    w_key;
  logic                   w_miso;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_win1 = req1_i & (~req0_i | prio1_q);
  assign w_mode = sel1_q ? mode1_i : mode0_i;
  assign w_nk   = sel1_q ? nk1_i   : nk0_i;
  assign w_data = sel1_q ? data1_i : data0_i;
  assign w_key  = sel1_q ? key1_i  : key0_i;
  assign w_miso = mode_q ? miso_enc_i : miso_dec_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sel1_q     <= 1'b0;
      prio1_q    <= 1'b0;
      mode_q     <= 1'b0;
      nk_q       <= 2'b00;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_enc_n_q <= 1'b1;
      cs_dec_n_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (req0_i || req1_i) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            sel1_q  <= w_win1;
            gnt0_q  <= ~w_win1;
            gnt1_q  <= w_win1;
            prio1_q <= ~w_win1;
          end
        end
        S_LOAD: begin
          mode_q     <= w_mode;
          nk_q       <= w_nk;
          tx_q       <= {w_data[DATA_BITS-2:0], w_key, 1'b0};
          mosi_q     <= w_data[DATA_BITS-1];
          cs_enc_n_q <= ~w_mode;
          cs_dec_n_q <= w_mode;
          cnt_q      <= '0;
          state_q    <= S_TX_DATA;
        end
        S_TX_DATA: begin
          mosi_q <= tx_q[FRAME_BITS-1];
          tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
          if (cnt_q == c_DATA_LAST) begin
            cnt_q   <= '0;
            state_q <= S_TX_KEY;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_TX_KEY: begin
          mosi_q <= tx_q[FRAME_BITS-1];
          tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
          if (cnt_q == c_KEY_LAST) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_WAIT: begin
          mosi_q <= 1'b0;
          if (cnt_q == c_WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_RX;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_RX: begin
          rx_q <= {rx_q[DATA_BITS-2:0], w_miso};
          if (cnt_q == c_RX_LAST) begin
            cnt_q      <= '0;
            cs_enc_n_q <= 1'b1;
            cs_dec_n_q <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        S_DONE: begin
          data_out_q <= rx_q;
          done0_q    <= ~sel1_q;
          done1_q    <= sel1_q;
          gnt0_q     <= 1'b0;
          gnt1_q     <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign done0_o    = done0_q;
  assign done1_o    = done1_q;
  assign data_out_o = data_out_q;
  assign busy_o     = busy_q;
  assign nk_val_o   = nk_q;
  assign mosi_o     = mosi_q;
  assign cs_enc_n_o = cs_enc_n_q;
  assign cs_dec_n_o = cs_dec_n_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_spi_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_spi_scheduler : directed self-checking bench with SPI slave models. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_spi_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 0, req1 = 0, mode0 = 0, mode1 = 0;
  logic [1:0]   nk0 = 0, nk1 = 0;
  logic [127:0] data0 = 0, data1 = 0;
  logic [255:0] key0 = 0, key1 = 0;
  logic         gnt0_o, gnt1_o, done0_o, done1_o, busy_o, mosi_o;
  logic         cs_enc_n_o, cs_dec_n_o;
  logic [127:0] data_out_o;
  logic [1:0]   nk_val_o;
  logic         miso_enc = 1'b1, miso_dec = 1'b1;

  aes_spi_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .mode0_i(mode0), .mode1_i(mode1),
    .nk0_i(nk0), .nk1_i(nk1), .data0_i(data0), .data1_i(data1),
    .key0_i(key0), .key1_i(key1),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .done0_o(done0_o), .done1_o(done1_o),
    .data_out_o(data_out_o), .busy_o(busy_o), .nk_val_o(nk_val_o), .mosi_o(mosi_o),
    .cs_enc_n_o(cs_enc_n_o), .cs_dec_n_o(cs_dec_n_o),
    .miso_enc_i(miso_enc), .miso_dec_i(miso_dec)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Link monitor and slave models; miso is presented on the falling edge.
  logic [127:0] resp_enc = 0, resp_dec = 0;
  logic [383:0] frame = 0;
  logic [1:0]   nk_exp = 0;
  int k = 0, idx = 0, cs_len = 0, zero_err = 0, nk_err = 0;
  int gnt_both = 0, cs_both = 0, done0_cnt = 0;
  bit enc_seen = 0, dec_seen = 0;

  always @(negedge clk) begin
    if (gnt0_o && gnt1_o) gnt_both++;
    if (!cs_enc_n_o && !cs_dec_n_o) cs_both++;
    if (done0_o) done0_cnt++;
    if (!cs_enc_n_o) enc_seen = 1;
    if (!cs_dec_n_o) dec_seen = 1;
    if (!cs_enc_n_o || !cs_dec_n_o) begin
      k++;
      if (k <= 384) frame = {frame[382:0], mosi_o};
      else if (mosi_o) zero_err++;
      if (nk_val_o != nk_exp) nk_err++;
    end else begin
      if (k != 0) cs_len = k;
      k = 0;
      if (mosi_o) zero_err++;
    end
    idx = k - 388;
    miso_enc = (!cs_enc_n_o && idx >= 0 && idx < 128) ? resp_enc[127-idx] : 1'b1;
    miso_dec = (!cs_dec_n_o && idx >= 0 && idx < 128) ? resp_dec[127-idx] : 1'b1;
  end

  task automatic do_txn(input int who, input logic md, input logic [1:0] nk,
                        input logic [127:0] d, input logic [255:0] ky,
                        input logic [127:0] resp, input bit perturb);
    int t;
    int g_cyc;
    if (who == 0) begin mode0 = md; nk0 = nk; data0 = d; key0 = ky; end
    else          begin mode1 = md; nk1 = nk; data1 = d; key1 = ky; end
    resp_enc = resp; resp_dec = resp; nk_exp = nk;
    frame = 0; zero_err = 0; nk_err = 0; enc_seen = 0; dec_seen = 0; cs_len = 0;
    if (who == 0) req0 = 1; else req1 = 1;
    t = 0;
    while (!(who == 0 ? gnt0_o : gnt1_o) && t < 20) begin @(posedge clk); #1; t++; end
    check_eq("gnt_seen", 384'(t < 20), 384'(1));
    g_cyc = cyc;
    if (perturb) begin
      @(posedge clk); #1;
      if (who == 0) begin data0 = ~d; key0 = ~ky; end
      else          begin data1 = ~d; key1 = ~ky; end
    end
    t = 0;
    while (!(who == 0 ? done0_o : done1_o) && t < 600) begin @(posedge clk); #1; t++; end
    if (who == 0) req0 = 0; else req1 = 0;
    check_eq("latency", 384'(cyc - g_cyc), 384'(517));
    check_eq("data_out", 384'(data_out_o), 384'(resp));
    check_eq("mosi_frame", frame, {d, ky});
    check_eq("mosi_zero", 384'(zero_err), 384'(0));
    check_eq("cs_len", 384'(cs_len), 384'(515));
    check_eq("cs_wrong_slave", 384'(md ? dec_seen : enc_seen), 384'(0));
    check_eq("cs_right_slave", 384'(md ? enc_seen : dec_seen), 384'(1));
    check_eq("nk_stable", 384'(nk_err), 384'(0));
    check_eq("gnt_dropped", 384'({gnt0_o, gnt1_o}), 384'(0));
    check_eq("done_other", 384'(who == 0 ? done1_o : done0_o), 384'(0));
    @(posedge clk); #1;
    check_eq("done_pulse_len", 384'({done0_o, done1_o, busy_o}), 384'(0));
    check_eq("data_out_hold", 384'(data_out_o), 384'(resp));
  endtask

  initial begin
    int t;
    int prev;
    int snap;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_eq("rst_ctrl", 384'({gnt0_o, gnt1_o, done0_o, done1_o, busy_o, mosi_o}), 384'(0));
    check_eq("rst_cs", 384'({cs_enc_n_o, cs_dec_n_o}), 384'(2'b11));
    check_eq("rst_data_nk", 384'({data_out_o, nk_val_o}), 384'(0));

    // Contention straight out of reset: req0 must win first, then alternate.
    mode0 = 1; mode1 = 0; resp_enc = 128'h1; resp_dec = 128'h2;
    req0 = 1; req1 = 1; prev = 0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!(gnt0_o || gnt1_o) && t < 20) begin @(posedge clk); #1; t++; end
      check_eq("arb_gnt_seen", 384'(t < 20), 384'(1));
      check_eq("arb_order", 384'({gnt1_o, gnt0_o}), 384'((i % 2) ? 2'b10 : 2'b01));
      if (i > 0) check_eq("arb_period", 384'(cyc - prev), 384'(518));
      prev = cyc;
      t = 0;
      while ((gnt0_o || gnt1_o) && t < 600) begin @(posedge clk); #1; t++; end
      check_eq("arb_release", 384'(t < 600), 384'(1));
      if (i == 3) begin req0 = 0; req1 = 0; end
    end
    repeat (3) @(posedge clk); #1;

    do_txn(0, 1'b1, 2'b00, 128'h00112233445566778899aabbccddeeff,
           {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    do_txn(1, 1'b0, 2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
           256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
           128'h00112233445566778899aabbccddeeff, 1'b0);
    do_txn(0, 1'b1, 2'b00, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f,
           256'hcafef00d_12345678_9abcdef0_0badbeef_55aa55aa_33cc33cc_0f0f0f0f_deadbeef,
           128'ha5a5a5a5_0000ffff_12345678_80000001, 1'b1);
    do_txn(0, 1'b1, 2'b11, 128'h0123456789abcdeffedcba9876543210,
           256'h8000000000000000000000000000000000000000000000000000000000000001,
           128'hdeadbeef_feedface_01234567_89abcdef, 1'b0);

    // Reset in the middle of a transaction.
    mode0 = 1; nk0 = 2'b01; data0 = 128'h5; key0 = 256'h7; req0 = 1;
    t = 0;
    while (!gnt0_o && t < 20) begin @(posedge clk); #1; t++; end
    check_eq("mid_gnt_seen", 384'(t < 20), 384'(1));
    repeat (200) @(posedge clk);
    #1 rst = 1; req0 = 0; snap = done0_cnt;
    #1;
    check_eq("mid_rst_ctrl", 384'({gnt0_o, gnt1_o, done0_o, done1_o, busy_o, mosi_o}), 384'(0));
    check_eq("mid_rst_cs", 384'({cs_enc_n_o, cs_dec_n_o}), 384'(2'b11));
    check_eq("mid_rst_data_nk", 384'({data_out_o, nk_val_o}), 384'(0));
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (20) @(posedge clk); #1;
    check_eq("mid_no_done", 384'(done0_cnt - snap), 384'(0));
    check_eq("mid_idle", 384'(busy_o), 384'(0));
    do_txn(0, 1'b1, 2'b00, 128'h00112233445566778899aabbccddeeff,
           {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);

    check_eq("gnt_exclusive", 384'(gnt_both), 384'(0));
    check_eq("cs_exclusive", 384'(cs_both), 384'(0));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/aes_spi_scheduler.md
# aes_spi_scheduler

Sequencing and arbitration controller for the shared AES SPI link. Two host requesters each submit a 128-bit block, a 256-bit key, a key-length code and an encrypt/decrypt mode. The block grants one requester at a time and drives the serial frame to the selected cipher or inverse-cipher SPI slave: data, then key, then wait, then result readback. It returns the 128-bit result with a per-requester done pulse.

## Interface
- DATA_BITS, 128, block width shifted out and read back
- KEY_BITS, 256, key bits shifted out; always full width regardless of Nk
- WAIT_CYCLES, 4, idle cycles (MOSI=0) between key and readback
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- req0, req1  in  1  level request; held until the matching done pulse
- mode0, mode1  in  1  1 = encrypt, 0 = decrypt
- nk0, nk1  in  2  key length: 00 = Nk4, 01 = Nk6, 10 = Nk8, 11 treated as Nk8
- data0, data1  in  DATA_BITS  plaintext or ciphertext block
- key0, key1  in  KEY_BITS  key, left-aligned
- gnt0, gnt1  out  1  requester owns the link, LOAD through DONE
- done0, done1  out  1  one-cycle pulse; data_out valid
- data_out  out  DATA_BITS  last result; holds until next DONE
- busy  out  1  state != IDLE
- nk_val  out  2  latched Nk code to both slaves; stable for whole transaction
- mosi  out  1  serial data to both slaves
- cs_enc_n, cs_dec_n  out  1  active-low slave selects
- miso_enc, miso_dec  in  1  serial result from each slave

## Operation
- States: IDLE, LOAD, TX_DATA, TX_KEY, WAIT, RX, DONE. A single 9-bit bit counter is shared across the shift states.
- IDLE: if any req is high, go to LOAD and assert gnt of the winner.
  - Round-robin arbitration: the last-granted requester loses a tie.
  - After reset, req0 wins a tie.
- LOAD (1 cycle): latch the winner's data, key, mode and nk into internal registers. Later input changes are ignored until the next LOAD.
- TX_DATA: 128 cycles; mosi = data bits MSB first (bit 127 first).
- TX_KEY: 256 cycles; mosi = key bits MSB first.
- WAIT: WAIT_CYCLES cycles with mosi = 0.
- RX: 128 cycles.
  - Sample the selected miso (miso_enc if mode = 1, else miso_dec) on each posedge.
  - Shift into the result register LSB, so the first bit received ends as bit 127.
- DONE (1 cycle): update data_out; pulse the granted done; drop gnt; drive both cs high; then go to IDLE.
- Chip select: only the selected slave's cs_n is low, from the first TX_DATA bit through the last RX sample. Both are high otherwise. They are never low simultaneously.
- A req still high in IDLE after done counts as a new request and is subject to round-robin.
- An unselected requester's req is ignored while busy; it is not lost, since req is level.

## Timing
- Reset values:
  - State IDLE; gnt0, gnt1, done0, done1, busy and mosi all 0.
  - cs_enc_n and cs_dec_n both 1; data_out 0; nk_val 00; round-robin pointer favouring req0.
- Let edge E be the posedge at which IDLE sees a req.
  - E: gnt and busy go high.
  - E+1: mosi = data[127], cs_n low.
  - E+128: last data bit.
  - E+129 to E+384: key bits.
  - E+385 to E+388: zeros.
  - miso sampled at edges E+389 to E+516.
  - E+517: DONE; done pulse and data_out valid for that cycle.
  - E+518: IDLE.
- Request-to-done latency is 517 cycles with default parameters; the link is back-to-back capable every 518 cycles.
- Simultaneous req0 and req1 in IDLE: the pointer decides; the loser is granted at the next IDLE if still requesting.
- Reset asserted mid-transaction forces reset values immediately, with no done pulse. The interrupted request is not replayed; its requester sees no done and must re-request.

## Test plan
- Single encrypt: req0 with mode0=1, nk0=00, data0=128'h00112233445566778899aabbccddeeff, key0={128'h000102030405060708090a0b0c0d0e0f,128'h0}; slave model returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a on miso_enc.
  - Required: done0 exactly 517 cycles after grant; data_out matches the returned value.
  - Required: cs_dec_n stays 1 throughout; mosi stream equals data then key, MSB first.
- Decrypt path: req1 with mode1=0, nk1=10, and miso_dec returning 128'h00112233445566778899aabbccddeeff. Required: only cs_dec_n goes low; nk_val=10 for the whole transaction; done1 pulses; data_out matches.
- Contention: req0 and req1 asserted in the same cycle after reset, held high.
  - Required: grants alternate 0, 1, 0, 1 across four transactions, each 518 cycles apart.
  - Required: gnt0 and gnt1 are never both high.
- Input stability: change data0 and key0 one cycle after grant. Required: the transmitted frame uses the values latched at LOAD.
- Reset mid-operation: assert rst at edge E+200 for 3 cycles. Required: all outputs at reset values asynchronously; no done pulse; a new req0 afterwards completes normally with 517-cycle latency.
- Nk code 11: required to behave as Nk8, with nk_val=11 passed through unchanged and the frame length unchanged.
